// File: rtl/add_seq_ctrl.sv
// Multi-byte add/subtract sequencer: one shared 8-bit adder walks the operands
// LSB byte first, chaining the carry through a flop, with a start/busy/done handshake.

module add_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
endmodule

module add_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op_sub,
  input  logic [8*WORDS-1:0] a,
  input  logic [8*WORDS-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [8*WORDS-1:0] result,
  output logic               carry_out,
  output logic               overflow
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [WORDS-1:0][7:0]     a_q, a_d;
  logic [WORDS-1:0][7:0]     b_q, b_d;
  logic                      carry_q, carry_d;
  logic [WORDS-1:0][7:0]     result_q, result_d;
  logic                      carry_out_q, carry_out_d;
  logic                      overflow_q, overflow_d;

  logic [7:0] add_a, add_b, add_sum;
  logic       add_cout;

  assign add_a = a_q[idx_q];
  assign add_b = b_q[idx_q];

  add_8_bit u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub;
          idx_d   = '0;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        result_d[idx_q] = add_sum;
        carry_d         = add_cout;
        idx_d           = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // b_q is already inverted for subtract, so one overflow rule covers both ops.
          carry_out_d = add_cout;
          overflow_d  = (a_q[WORDS-1][7] == b_q[WORDS-1][7]) &&
                        (add_sum[7] != a_q[WORDS-1][7]);
          idx_d       = '0;
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: a WORDS=4 and a WORDS=1 instance, directed plus random
// operations checked against an arithmetic model of unsigned/signed results.

module tb_add_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start4 = 1'b0, op_sub4 = 1'b0;
  logic [31:0] a4 = '0, b4 = '0;
  logic        busy4, done4, carry4, ovf4;
  logic [31:0] result4;

  logic        start1 = 1'b0, op_sub1 = 1'b0;
  logic [7:0]  a1 = '0, b1 = '0;
  logic        busy1, done1, carry1, ovf1;
  logic [7:0]  result1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_seq_ctrl #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op_sub(op_sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .carry_out(carry4), .overflow(ovf4)
  );

  add_seq_ctrl #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_sub(op_sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(result1), .carry_out(carry1), .overflow(ovf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic plus signed-range test on true integers.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit sub,
                                input int nb, output logic [31:0] r, output logic c,
                                output logic v);
    longint unsigned m, ua, ub, s;
    longint sa, sb, sr, half;
    m    = 64'd1 << (8 * nb);
    half = longint'(m / 2);
    ua   = {32'd0, a} & (m - 1);
    ub   = {32'd0, b} & (m - 1);
    s    = sub ? ua + (m - ub) : ua + ub;
    r    = 32'(s % m);
    c    = (s >= m);
    sa   = (longint'(ua) >= half) ? longint'(ua) - longint'(m) : longint'(ua);
    sb   = (longint'(ub) >= half) ? longint'(ub) - longint'(m) : longint'(ub);
    sr   = sub ? sa - sb : sa + sb;
    v    = (sr < -half) || (sr >= half);
  endfunction

  function automatic logic get_done(input bit one);
    return one ? done1 : done4;
  endfunction

  function automatic logic get_busy(input bit one);
    return one ? busy1 : busy4;
  endfunction

  task automatic drive(input bit one, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input bit sub);
    if (one) begin
      start1 = st; a1 = a[7:0]; b1 = b[7:0]; op_sub1 = sub;
    end else begin
      start4 = st; a4 = a; b4 = b; op_sub4 = sub;
    end
  endtask

  // Issue one operation, scramble the inputs after acceptance, time the done pulse.
  task automatic do_op(input bit one, input logic [31:0] a, input logic [31:0] b,
                       input bit sub, input string tag);
    logic [31:0] er;
    logic ec, ev;
    int nb, n, busy_cnt;
    nb = one ? 1 : 4;
    model(a, b, sub, nb, er, ec, ev);
    @(negedge clk);
    drive(one, 1'b1, a, b, sub);
    @(negedge clk);
    drive(one, 1'b0, $urandom, $urandom, 1'($urandom));
    n = 1;
    busy_cnt = 0;
    while (!get_done(one) && n < 40) begin
      if (get_busy(one)) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(nb + 1));
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(nb));
    check({tag, ".result"}, one ? {24'd0, result1} : result4, er);
    check({tag, ".carry"}, 32'(one ? carry1 : carry4), 32'(ec));
    check({tag, ".ovf"}, 32'(one ? ovf1 : ovf4), 32'(ev));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(get_done(one)), 32'd0);
    check({tag, ".result_held"}, one ? {24'd0, result1} : result4, er);
  endtask

  initial begin
    int n, dcount;
    logic [31:0] held, er;
    logic ec, ev;

    // Reset state while rst is asserted
    #1;
    check("rst.busy4", 32'(busy4), 32'd0);
    check("rst.done4", 32'(done4), 32'd0);
    check("rst.result4", result4, 32'd0);
    check("rst.carry4", 32'(carry4), 32'd0);
    check("rst.ovf4", 32'(ovf4), 32'd0);
    check("rst.result1", {24'd0, result1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed add/subtract corner cases
    do_op(1'b0, 32'h000000FF, 32'h00000001, 1'b0, "t1");
    do_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, "t2a");
    do_op(1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, "t2b");
    do_op(1'b0, 32'h00000005, 32'h00000007, 1'b1, "t3a");
    do_op(1'b0, 32'h80000000, 32'h00000001, 1'b1, "t3b");

    // Reset during RUN at idx=2 (previous op left carry_out=1, overflow=1)
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h01020304, 32'h10203040, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t6.busy_before", 32'(busy4), 32'd1);
    rst = 1'b1;
    #1;
    check("t6.busy", 32'(busy4), 32'd0);
    check("t6.done", 32'(done4), 32'd0);
    check("t6.result", result4, 32'd0);
    check("t6.carry", 32'(carry4), 32'd0);
    check("t6.ovf", 32'(ovf4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done4) dcount++;
    end
    check("t6.no_done", 32'(dcount), 32'd0);
    do_op(1'b0, 32'hCAFEBABE, 32'h12345678, 1'b0, "t6.after");

    // start pulsed during the 2nd RUN cycle is ignored
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h01020304, 32'h10203040, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h11111111, 32'h22222222, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    dcount = 0;
    held = '0;
    for (int i = 0; i < 12; i++) begin
      if (done4) begin
        dcount++;
        held = result4;
      end
      @(negedge clk);
    end
    check("t4.done_count", 32'(dcount), 32'd1);
    check("t4.result", held, 32'h11223344);

    // Back-to-back: start held through the DONE cycle
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h12345678, 32'h11111111, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    n = 0;
    while (!done4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t5.first_done", 32'(done4), 32'd1);
    check("t5.first_result", result4, 32'h23456789);
    drive(1'b0, 1'b1, 32'h00001000, 32'h00002000, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("t5.no_bubble", 32'(busy4), 32'd1);
    check("t5.result_held", result4, 32'h23456789);
    n = 1;
    while (!done4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t5.done_spacing", 32'(n), 32'd5);
    check("t5.second_result", result4, 32'hFFFFF000);
    check("t5.second_carry", 32'(carry4), 32'd0);

    // WORDS=1 instance
    do_op(1'b1, 32'hFF, 32'h01, 1'b0, "w1.a");
    do_op(1'b1, 32'h80, 32'h01, 1'b1, "w1.b");
    for (int i = 0; i < 8; i++)
      do_op(1'b1, $urandom, $urandom, 1'($urandom), $sformatf("w1.rnd%0d", i));

    // Random WORDS=4 operations
    for (int i = 0; i < 20; i++)
      do_op(1'b0, $urandom, $urandom, 1'($urandom), $sformatf("rnd%0d", i));

    // Model self-consistency spot value used above
    model(32'h01020304, 32'h10203040, 1'b0, 4, er, ec, ev);
    check("model.t4", er, 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
